pec_pkt_dispatch: RTL

Ingress packet extraction/dispatch stage directly upstream of the device route controller (DRC).
- Accepts a 32-bit beat stream from the port mux and reassembles fixed 5-beat packets.
- Validates type and source port, then buffers complete packets in a small FIFO.
- Issues each packet as a single-cycle pktDis* pulse to DRC, enforcing a minimum inter-dispatch gap so DRC lookups never overlap.

---
 rtl/pec_pkt_dispatch_if.sv | 28 ++
 rtl/pec_pkt_dispatch.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pec_pkt_dispatch_if.sv
// Beat stream from the port mux into the packet extraction stage.
// The source drives the beat, the sink answers with ready.
interface pec_pkt_dispatch_if;
    logic        PEC_IN_valid;
    logic        PEC_IN_ready;
    logic        PEC_IN_sop;
    logic        PEC_IN_eop;
    logic [31:0] PEC_IN_data;
    logic [4:0]  PEC_IN_port;

    modport master (
        output PEC_IN_valid,
        output PEC_IN_sop,
        output PEC_IN_eop,
        output PEC_IN_data,
        output PEC_IN_port,
        input  PEC_IN_ready
    );

    modport slave (
        input  PEC_IN_valid,
        input  PEC_IN_sop,
        input  PEC_IN_eop,
        input  PEC_IN_data,
        input  PEC_IN_port,
        output PEC_IN_ready
    );
endinterface

// File: rtl/pec_pkt_dispatch.sv
// Ingress packet extraction: reassembles 5-beat packets, validates,
// buffers them and issues gap-spaced single-cycle pulses to DRC.
module pec_pkt_dispatch #(
    parameter int DEPTH      = 2,
    parameter int GAP_CYCLES = 2,
    parameter int ERRW       = 8
) (
    input  logic                 iClk,
    input  logic                 iResetN,
    pec_pkt_dispatch_if.slave    pec_in,
    output logic                 DRC_PEC_pktDisValid,
    output logic [5:0]           DRC_PEC_pktDisType,
    output logic [127:0]         DRC_PEC_pktDisData,
    output logic [15:0]          DRC_PEC_pktDisAddr,
    output logic [4:0]           DRC_PEC_pktDisPort,
    output logic [ERRW-1:0]      PEC_errCnt,
    output logic                 PEC_dropPulse
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [15:0] GAPV = 16'(GAP_CYCLES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    typedef struct packed {
        logic [5:0]   typ;
        logic [15:0]  addr;
        logic [4:0]   port;
        logic [127:0] data;
    } ent_t;

    logic [1:0]  state_q, state_d;
    logic [5:0]  type_q, type_d;
    logic [15:0] addr_q, addr_d;
    logic [4:0]  port_q, port_d;
    logic [95:0] data_q, data_d;
    logic [1:0]  cnt_q, cnt_d;

    logic        acc, hdr, ok, err, push, pop, full, empty;
    logic [AW:0] wp_q, rp_q;
    ent_t        mem [DEPTH];
    ent_t        head, wr_ent;
    ent_t        dis_q;
    logic        vld_q;
    logic [15:0] gap_q;
    logic [ERRW-1:0] err_q;
    logic        drop_q;

    assign full  = (wp_q[AW] != rp_q[AW]) &&
                   (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign empty = (wp_q == rp_q);
    assign pop   = ~empty && (gap_q == 16'd0);
    assign head  = mem[rp_q[AW-1:0]];

    assign pec_in.PEC_IN_ready = (state_q == S_DROP) | ~full;

    assign acc = pec_in.PEC_IN_valid & pec_in.PEC_IN_ready;
    assign hdr = pec_in.PEC_IN_sop & ~pec_in.PEC_IN_eop;
    assign ok  = (type_q >= 6'd1) && (type_q <= 6'd5) &&
                 (port_q != 5'd0);

    assign wr_ent = '{typ:  type_q,
                      addr: addr_q,
                      port: port_q,
                      data: {pec_in.PEC_IN_data, data_q}};

    // Beat-level framing FSM; only accepted beats advance it.
    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        addr_d  = addr_q;
        port_d  = port_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        err     = 1'b0;
        push    = 1'b0;
        if (acc) begin
            case (state_q)
                S_IDLE: begin
                    if (hdr) begin
                        type_d  = pec_in.PEC_IN_data[5:0];
                        addr_d  = pec_in.PEC_IN_data[21:6];
                        port_d  = pec_in.PEC_IN_port;
                        cnt_d   = 2'd0;
                        state_d = S_DATA;
                    end else begin
                        err = 1'b1;
                    end
                end
                S_DATA: begin
                    if (pec_in.PEC_IN_sop) begin
                        // abort; the beat restarts as a header
                        err = 1'b1;
                        if (hdr) begin
                            type_d  = pec_in.PEC_IN_data[5:0];
                            addr_d  = pec_in.PEC_IN_data[21:6];
                            port_d  = pec_in.PEC_IN_port;
                            cnt_d   = 2'd0;
                            state_d = S_DATA;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else if (cnt_q == 2'd3) begin
                        if (pec_in.PEC_IN_eop) begin
                            state_d = S_IDLE;
                            if (ok && !full) push = 1'b1;
                            else             err  = 1'b1;
                        end else begin
                            err     = 1'b1;
                            state_d = S_DROP;
                        end
                    end else if (pec_in.PEC_IN_eop) begin
                        err     = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        data_d[{cnt_q, 5'd0} +: 32] = pec_in.PEC_IN_data;
                        cnt_d = cnt_q + 2'd1;
                    end
                end
                S_DROP: begin
                    if (pec_in.PEC_IN_eop) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Framing state and the packet under assembly.
    always_ff @(posedge iClk or negedge iResetN) begin
        if (!iResetN) begin
            state_q <= S_IDLE;
            type_q  <= '0;
            addr_q  <= '0;
            port_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            addr_q  <= addr_d;
            port_q  <= port_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    // Packet FIFO storage; contents are only meaningful between pointers.
    always_ff @(posedge iClk) begin
        if (push) mem[wp_q[AW-1:0]] <= wr_ent;
    end

    // FIFO pointers; reset empties the queue.
    always_ff @(posedge iClk or negedge iResetN) begin
        if (!iResetN) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            if (push) wp_q <= wp_q + (AW+1)'(1);
            if (pop)  rp_q <= rp_q + (AW+1)'(1);
        end
    end

    // Registered dispatch pulse and inter-dispatch gap counter.
    always_ff @(posedge iClk or negedge iResetN) begin
        if (!iResetN) begin
            vld_q <= 1'b0;
            dis_q <= '0;
            gap_q <= '0;
        end else begin
            vld_q <= pop;
            dis_q <= pop ? head : '0;
            if (pop)                gap_q <= GAPV;
            else if (gap_q != 16'd0) gap_q <= gap_q - 16'd1;
        end
    end

    // Saturating error counter and drop pulse.
    always_ff @(posedge iClk or negedge iResetN) begin
        if (!iResetN) begin
            err_q  <= '0;
            drop_q <= 1'b0;
        end else begin
            drop_q <= err;
            if (err && (err_q != '1)) err_q <= err_q + 1'b1;
        end
    end

    assign DRC_PEC_pktDisValid = vld_q;
    assign DRC_PEC_pktDisType  = dis_q.typ;
    assign DRC_PEC_pktDisAddr  = dis_q.addr;
    assign DRC_PEC_pktDisPort  = dis_q.port;
    assign DRC_PEC_pktDisData  = dis_q.data;
    assign PEC_errCnt          = err_q;
    assign PEC_dropPulse       = drop_q;

endmodule
